gpio_apb_arbiter: RTL
=====================

// Module: gpio_apb_arbiter
// PURPOSE
//  Two-requester APB master that shares the single rev_gpio APB slave port between requesters.
//  Arbitrates round-robin, latches the winner's command and runs a standard SETUP/ACCESS APB transfer.
//  Supports PREADY wait states and a watchdog timeout, then returns read data and error status.
//  Sits between the on-chip command sources and rev_gpio.
// PARAMETERS
//  GPIO_PINS   32  data width; multiple of 8; PSTRB width = GPIO_PINS/8
//  PADDR_SIZE  4   APB address width
//  TIMEOUT     16  max ACCESS cycles waiting for pready before abort (>=1)
// PORTS
//  pclk       in   1                 clock, all logic on rising edge
//  prst       in   1                 reset, synchronous, active-high
//  req        in   2                 req[i]=1: requester i has a command; hold until ack[i]
//  req_addr   in   2*PADDR_SIZE      slot i at [i*PADDR_SIZE +: PADDR_SIZE]
//  req_write  in   2                 1=write, 0=read, per requester
//  req_wdata  in   2*GPIO_PINS       slot i at [i*GPIO_PINS +: GPIO_PINS]
//  req_strb   in   2*GPIO_PINS/8     slot i at [i*GPIO_PINS/8 +: GPIO_PINS/8]
//  ack        out  2                 one-cycle completion pulse to requester i
//  rdata      out  GPIO_PINS         read data, valid while ack is high
//  err        out  1                 1 = pslverr or timeout, valid while ack is high
//  busy       out  1                 1 in any state except IDLE
//  psel       out  1                 APB select
//  penable    out  1                 APB enable
//  paddr      out  PADDR_SIZE        APB address
//  pwrite     out  1                 APB direction
//  pwdata     out  GPIO_PINS         APB write data
//  pstrb      out  GPIO_PINS/8       APB byte strobes; all 0 on reads
//  pready     in   1                 APB ready from slave
//  prdata     in   GPIO_PINS         APB read data from slave
//  pslverr    in   1                 APB error from slave
// BEHAVIOUR
//  Reset: all outputs 0; FSM=IDLE; last_grant=1 so requester 0 wins the first tie; timeout counter 0.
//  FSM states: IDLE -> SETUP -> ACCESS -> RESP -> IDLE.
//  IDLE: if any req is set, grant it; if both are set, grant !last_grant.
//   - Latch addr/write/wdata/strb of the grantee and update last_grant; next state SETUP.
//  SETUP: psel=1, penable=0; paddr/pwrite/pwdata/pstrb driven from latched command; next state ACCESS.
//  ACCESS: psel=1, penable=1; APB outputs stable. Counter increments each ACCESS cycle.
//   - pready=1: capture rdata=prdata on reads (0 on writes) and err=pslverr; next state RESP.
//   - pready=0 for TIMEOUT cycles: abort with rdata=0, err=1; next state RESP.
//  RESP: psel=penable=0; ack[grantee]=1 for exactly this cycle; next state IDLE. req is not sampled in RESP.
//  All APB outputs are registered. psel/penable/paddr/pwrite/pwdata/pstrb return to 0 outside SETUP/ACCESS.
//  rdata/err hold their value until the next RESP.
//  Latency with pready=1 in the first ACCESS cycle:
//   - req sampled in IDLE at edge N; SETUP at N+1; ACCESS at N+2; ack at N+3.
//   - 4-cycle throughput per transfer.
//  Boundaries:
//   - Requester drops req mid-transfer: transfer completes and ack still pulses.
//   - Both req held continuously: grants alternate 0,1,0,1...
//   - pready asserted in the same cycle the counter reaches TIMEOUT: pready wins (normal completion).
//   - prst mid-transfer: next edge forces IDLE with all outputs 0, no ack, last_grant=1.
//   - req_* changes after grant: ignored (command latched).
// TESTING
//  1 r0 read addr 4'h0, pready=1, prdata=32'hA5A5_0001 -> psel@N+1, penable@N+2, ack=2'b01@N+3, rdata=32'hA5A5_0001, err=0
//  2 r1 write addr 4'h4, data 32'hDEAD_BEEF, strb 4'b0011 -> pwrite=1, pwdata=32'hDEAD_BEEF, pstrb=4'b0011 in SETUP/ACCESS; ack=2'b10; read pstrb=0
//  3 after reset both req held for 4 transfers -> ack order 01,10,01,10; psel never asserted in RESP
//  4 pready low 3 ACCESS cycles then high -> ACCESS lasts 4 cycles, APB outputs stable, ack one cycle later, err=0
//  5 pready never asserted, TIMEOUT=16 -> 16 ACCESS cycles, psel drops, ack with err=1, rdata=0; pslverr=1 with pready=1 -> err=1
//  6 prst=1 during ACCESS of r1 -> psel=penable=0 next edge, no ack; then both req -> r0 granted first

Source files
------------

// File: rtl/gpio_apb_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : gpio_apb_arbiter
// Description : Round-robin APB master sharing one rev_gpio slave port between
//               two command requesters, with PREADY wait states and timeout.
// Revision    : 1.0 - initial release
// ============================================================================
module gpio_apb_arbiter #(
    parameter int GPIO_PINS  = 32,
    parameter int PADDR_SIZE = 4,
    parameter int TIMEOUT    = 16
) (
    input  logic                       pclk,
    input  logic                       prst,
    input  logic [1:0]                 req,
    input  logic [2*PADDR_SIZE-1:0]    req_addr,
    input  logic [1:0]                 req_write,
    input  logic [2*GPIO_PINS-1:0]     req_wdata,
    input  logic [2*(GPIO_PINS/8)-1:0] req_strb,
    output logic [1:0]                 ack,
    output logic [GPIO_PINS-1:0]       rdata,
    output logic                       err,
    output logic                       busy,
    output logic                       psel,
    output logic                       penable,
    output logic [PADDR_SIZE-1:0]      paddr,
    output logic                       pwrite,
    output logic [GPIO_PINS-1:0]       pwdata,
    output logic [GPIO_PINS/8-1:0]     pstrb,
    input  logic                       pready,
    input  logic [GPIO_PINS-1:0]       prdata,
    input  logic                       pslverr
);

    localparam int c_strb_w = GPIO_PINS / 8;
    localparam int c_cnt_w  = $clog2(TIMEOUT + 1);
    localparam logic [c_cnt_w-1:0] c_cnt_last = c_cnt_w'(TIMEOUT - 1);

    localparam logic [1:0] c_st_idle   = 2'd0;
    localparam logic [1:0] c_st_setup  = 2'd1;
    localparam logic [1:0] c_st_access = 2'd2;
    localparam logic [1:0] c_st_resp   = 2'd3;

    logic [1:0]            r_state;
    logic                  r_gnt;
    logic                  r_last_grant;
    logic [c_cnt_w-1:0]    r_cnt;
    logic [1:0]            r_ack;
    logic [GPIO_PINS-1:0]  r_rdata;
    logic                  r_err;
    logic                  r_psel;
    logic                  r_penable;
    logic [PADDR_SIZE-1:0] r_paddr;
    logic                  r_pwrite;
    logic [GPIO_PINS-1:0]  r_pwdata;
    logic [c_strb_w-1:0]   r_pstrb;

    logic                  w_gnt;
    logic [PADDR_SIZE-1:0] w_addr;
    logic                  w_write;
    logic [GPIO_PINS-1:0]  w_wdata;
    logic [c_strb_w-1:0]   w_strb;
    logic                  w_done;

    // On a tie the requester that did not win last time is granted.
    always_comb begin
        w_gnt = req[1];
        if (req == 2'b11) begin
            w_gnt = ~r_last_grant;
        end
    end

    assign w_addr  = w_gnt ? req_addr[PADDR_SIZE +: PADDR_SIZE] : req_addr[0 +: PADDR_SIZE];
    assign w_write = w_gnt ? req_write[1] : req_write[0];
    assign w_wdata = w_gnt ? req_wdata[GPIO_PINS +: GPIO_PINS] : req_wdata[0 +: GPIO_PINS];
    assign w_strb  = w_gnt ? req_strb[c_strb_w +: c_strb_w] : req_strb[0 +: c_strb_w];

    // pready is checked ahead of the limit so a late ready still completes normally.
    assign w_done = pready || (r_cnt == c_cnt_last);

    always_ff @(posedge pclk) begin
        if (prst) begin
            r_state      <= c_st_idle;
            r_gnt        <= 1'b0;
            r_last_grant <= 1'b1;
            r_cnt        <= '0;
            r_ack        <= 2'b00;
            r_rdata      <= '0;
            r_err        <= 1'b0;
            r_psel       <= 1'b0;
            r_penable    <= 1'b0;
            r_paddr      <= '0;
            r_pwrite     <= 1'b0;
            r_pwdata     <= '0;
            r_pstrb      <= '0;
        end else begin
            r_ack <= 2'b00;
            case (r_state)
                c_st_idle: begin
                    if (|req) begin
                        r_gnt        <= w_gnt;
                        r_last_grant <= w_gnt;
                        r_psel       <= 1'b1;
                        r_paddr      <= w_addr;
                        r_pwrite     <= w_write;
                        r_pwdata     <= w_wdata;
                        r_pstrb      <= w_write ? w_strb : '0;
                        r_cnt        <= '0;
                        r_state      <= c_st_setup;
                    end
                end
                c_st_setup: begin
                    r_penable <= 1'b1;
                    r_cnt     <= '0;
                    r_state   <= c_st_access;
                end
                c_st_access: begin
                    if (w_done) begin
                        r_rdata   <= (pready && !r_pwrite) ? prdata : '0;
                        r_err     <= pready ? pslverr : 1'b1;
                        r_ack     <= r_gnt ? 2'b10 : 2'b01;
                        r_psel    <= 1'b0;
                        r_penable <= 1'b0;
                        r_paddr   <= '0;
                        r_pwrite  <= 1'b0;
                        r_pwdata  <= '0;
                        r_pstrb   <= '0;
                        r_cnt     <= '0;
                        r_state   <= c_st_resp;
                    end else begin
                        r_cnt <= r_cnt + c_cnt_w'(1);
                    end
                end
                c_st_resp: begin
                    r_state <= c_st_idle;
                end
                default: begin
                    r_state <= c_st_idle;
                end
            endcase
        end
    end

    assign ack     = r_ack;
    assign rdata   = r_rdata;
    assign err     = r_err;
    assign busy    = (r_state != c_st_idle);
    assign psel    = r_psel;
    assign penable = r_penable;
    assign paddr   = r_paddr;
    assign pwrite  = r_pwrite;
    assign pwdata  = r_pwdata;
    assign pstrb   = r_pstrb;

endmodule
`default_nettype wire
